// File: rtl/uds_pkg.sv
// Shared encodings, FSM state type and command check for the up/down-sample sequencer.
package uds_pkg;

    localparam int MODE_UP_BIT  = 1;
    localparam int MODE_AVG_BIT = 0;

    typedef enum logic [1:0] {
        MODE_DN_MAX = 2'b00,
        MODE_DN_AVG = 2'b01,
        MODE_UP_MAX = 2'b10,
        MODE_UP_AVG = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SCALE_2X2 = 2'd0,
        SCALE_3X3 = 2'd1
    } scale_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_COMPUTE,
        ST_WAIT_OUT,
        ST_HANDOFF
    } state_e;

    // Only 2x2 downsampling (max or avg) is implemented by the engine.
    function automatic logic cmd_supported(input logic [1:0] mode, input logic [1:0] scale);
        return !mode[MODE_UP_BIT] && (scale == SCALE_2X2);
    endfunction

endpackage

// File: rtl/uds_seq_perf.sv
// Saturating performance counters for the sequencer; only built when UDS_SEQ_PERF_EN is defined.
module uds_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        busy,
    input  logic        stall,
    input  logic        tile_done,
    output logic [31:0] busy_cyc,
    output logic [31:0] stall_cyc,
    output logic [31:0] tiles
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cyc  <= '0;
            stall_cyc <= '0;
            tiles     <= '0;
        end else if (clr) begin
            busy_cyc  <= '0;
            stall_cyc <= '0;
            tiles     <= '0;
        end else begin
            if (busy && (busy_cyc != '1))
                busy_cyc <= busy_cyc + 32'd1;
            if (stall && (stall_cyc != '1))
                stall_cyc <= stall_cyc + 32'd1;
            if (tile_done && (tiles != '1))
                tiles <= tiles + 32'd1;
        end
    end

endmodule

// File: rtl/uds_seq_ctrl.sv
// Job sequencer for the up/down-sample engine: fetch, load, compute, wait, handoff per tile.
// Optional perf counters are present when UDS_SEQ_PERF_EN is defined.
//
// state       | meaning
// IDLE        | ready for a command
// FETCH       | reject bad/empty job, else request tile until rd_ack
// LOAD        | one cycle of eng_idata_valid
// COMPUTE     | one cycle of eng_active
// WAIT_OUT    | wait for eng_odata_valid, bounded by WAIT_MAX
// HANDOFF     | out_valid held until out_ready
module uds_seq_ctrl
    import uds_pkg::*;
#(
    parameter int TILE_CNT_W = 16,
    parameter int WAIT_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [1:0]            cmd_scale,
    input  logic [TILE_CNT_W-1:0] cmd_tiles,
    output logic                  rd_req,
    input  logic                  rd_ack,
    output logic                  eng_active,
    output logic                  eng_idata_valid,
    output logic [1:0]            eng_mode,
    output logic [1:0]            eng_scale,
    input  logic                  eng_odata_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef UDS_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_busy_cyc,
    output logic [31:0]           perf_stall_cyc,
    output logic [31:0]           perf_tiles
`endif
);

    localparam int TMR_W = $clog2(WAIT_MAX + 1);

    state_e                state, state_nxt;
    logic [1:0]            mode_q, scale_q;
    logic [TILE_CNT_W-1:0] tiles_q, cnt_q, cnt_inc;
    logic [TMR_W-1:0]      tmr_q;
    logic                  accept, cmd_ok, tile_xfer;

    assign accept    = cmd_valid && (state == ST_IDLE);
    assign cmd_ok    = cmd_supported(mode_q, scale_q);
    assign tile_xfer = (state == ST_HANDOFF) && out_ready;
    assign cnt_inc   = cnt_q + TILE_CNT_W'(1);
    assign busy      = (state != ST_IDLE);
    assign eng_mode  = mode_q;
    assign eng_scale = scale_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mode_q  <= '0;
            scale_q <= '0;
            tiles_q <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mode_q  <= cmd_mode;
                scale_q <= cmd_scale;
                tiles_q <= cmd_tiles;
                cnt_q   <= '0;
            end else if (tile_xfer) begin
                cnt_q <= cnt_inc;
            end
            // Timer loads on the way into WAIT_OUT so its first cycle sees WAIT_MAX.
            if (state == ST_COMPUTE)
                tmr_q <= TMR_W'(WAIT_MAX);
            else if ((state == ST_WAIT_OUT) && (tmr_q != '0))
                tmr_q <= tmr_q - TMR_W'(1);
        end
    end

    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        rd_req          = 1'b0;
        eng_active      = 1'b0;
        eng_idata_valid = 1'b0;
        out_valid       = 1'b0;
        done            = 1'b0;
        err             = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (!cmd_ok) begin
                    err       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tiles_q == '0) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    rd_req = 1'b1;
                    if (rd_ack)
                        state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                eng_idata_valid = 1'b1;
                state_nxt       = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                eng_active = 1'b1;
                state_nxt  = ST_WAIT_OUT;
            end
            ST_WAIT_OUT: begin
                if (tmr_q == '0) begin
                    err       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (eng_odata_valid) begin
                    state_nxt = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_inc == tiles_q) begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef UDS_SEQ_PERF_EN
    logic stall;
    assign stall = (rd_req && !rd_ack) || (out_valid && !out_ready);

    uds_seq_perf u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .busy      (busy),
        .stall     (stall),
        .tile_done (tile_xfer),
        .busy_cyc  (perf_busy_cyc),
        .stall_cyc (perf_stall_cyc),
        .tiles     (perf_tiles)
    );
`endif

endmodule

// File: tb/tb_uds_seq_ctrl.sv
// Self-checking bench for uds_seq_ctrl: job table with a handoff/done/err event scoreboard.
module tb_uds_seq_ctrl;

    localparam int TILE_CNT_W = 16;
    localparam int WAIT_MAX   = 8;
    localparam int EV_HAND    = 1;
    localparam int EV_DONE    = 2;
    localparam int EV_ERR     = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [1:0]            cmd_mode = '0;
    logic [1:0]            cmd_scale = '0;
    logic [TILE_CNT_W-1:0] cmd_tiles = '0;
    logic                  rd_req;
    logic                  rd_ack = 1'b0;
    logic                  eng_active, eng_idata_valid;
    logic [1:0]            eng_mode, eng_scale;
    logic                  eng_odata_valid = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  busy, done, err;
`ifdef UDS_SEQ_PERF_EN
    logic [31:0]           perf_busy_cyc, perf_stall_cyc, perf_tiles;
`endif

    always #5 clk = ~clk;

    uds_seq_ctrl #(.TILE_CNT_W(TILE_CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_mode        (cmd_mode),
        .cmd_scale       (cmd_scale),
        .cmd_tiles       (cmd_tiles),
        .rd_req          (rd_req),
        .rd_ack          (rd_ack),
        .eng_active      (eng_active),
        .eng_idata_valid (eng_idata_valid),
        .eng_mode        (eng_mode),
        .eng_scale       (eng_scale),
        .eng_odata_valid (eng_odata_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .done            (done),
        .err             (err)
`ifdef UDS_SEQ_PERF_EN
        ,
        .perf_busy_cyc   (perf_busy_cyc),
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_tiles      (perf_tiles)
`endif
    );

    typedef struct {
        logic [1:0] mode;
        logic [1:0] scale;
        int         tiles;
        int         stall;      // out_ready low cycles on the first handoff
        int         ack_wait;   // rd_ack low cycles per tile fetch
        bit         eng_ok;     // engine strobes one cycle after COMPUTE
        bit         stray;      // eng_odata_valid also pulsed during FETCH
        int         exp_loads;
        int         exp_hand;
        bit         exp_err;
        bit         exp_timeout;
    } job_t;

    job_t jobs[11];
    int   sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input int kind);
        int want;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: DUT event %0d but scoreboard empty", name, kind);
        end else begin
            want = sb_q.pop_front();
            if (want != kind) begin
                errors++;
                $display("FAIL %s: DUT event %0d expected event %0d", name, kind, want);
            end
        end
    endtask

    function automatic job_t mk(input logic [1:0] mode, input logic [1:0] scale, input int tiles,
                                input int stall, input int ack_wait, input bit eng_ok, input bit stray);
        job_t j;
        j.mode = mode; j.scale = scale; j.tiles = tiles; j.stall = stall;
        j.ack_wait = ack_wait; j.eng_ok = eng_ok; j.stray = stray;
        j.exp_timeout = 1'b0;
        if (mode[1] || scale != 2'd0) begin
            j.exp_loads = 0; j.exp_hand = 0; j.exp_err = 1'b1;
        end else if (tiles == 0) begin
            j.exp_loads = 0; j.exp_hand = 0; j.exp_err = 1'b0;
        end else if (!eng_ok) begin
            j.exp_loads = 1; j.exp_hand = 0; j.exp_err = 1'b1; j.exp_timeout = 1'b1;
        end else begin
            j.exp_loads = tiles; j.exp_hand = tiles; j.exp_err = 1'b0;
        end
        return j;
    endfunction

    task automatic run_job(input int id, input job_t j);
        int    loads, rdreqs, ov_first, hands, stall_left, ack_left, wait_entry, end_tick;
        bit    fin, prev_act, eng_pend;
        string tag;
        tag = $sformatf("job%0d", id);
        loads = 0; rdreqs = 0; ov_first = 0; hands = 0; wait_entry = -100; end_tick = -1;
        fin = 0; prev_act = 0; eng_pend = 0;
        stall_left = j.stall; ack_left = j.ack_wait;
        @(negedge clk);
        check({tag, " cmd_ready_idle"}, cmd_ready, 1);
        cmd_mode = j.mode; cmd_scale = j.scale; cmd_tiles = TILE_CNT_W'(j.tiles); cmd_valid = 1'b1;
        repeat (j.exp_hand) sb_q.push_back(EV_HAND);
        sb_q.push_back(j.exp_err ? EV_ERR : EV_DONE);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_mode = ~j.mode; cmd_scale = ~j.scale; cmd_tiles = '1;
        for (int tick = 0; tick < 200 && !fin; tick++) begin
            eng_odata_valid = (eng_pend && j.eng_ok) || (j.stray && rd_req);
            eng_pend = eng_active;
            if (rd_req && ack_left > 0) begin rd_ack = 1'b0; ack_left--; end
            else rd_ack = 1'b1;
            if (out_valid && hands == 0 && stall_left > 0) begin out_ready = 1'b0; stall_left--; end
            else out_ready = 1'b1;
            #1;
            if (rd_req) rdreqs++;
            if (eng_idata_valid) loads++;
            if (prev_act) wait_entry = tick;
            if (out_valid && hands == 0) ov_first++;
            check({tag, " busy"}, busy, 1);
            check({tag, " ready_vs_busy"}, cmd_ready, !busy);
            check({tag, " eng_mode"}, eng_mode, j.mode);
            check({tag, " eng_scale"}, eng_scale, j.scale);
            if (out_valid && out_ready) begin
                sb_pop({tag, " handoff"}, EV_HAND);
                hands++;
                ack_left = j.ack_wait;
            end
            if (done) begin sb_pop({tag, " done"}, EV_DONE); fin = 1; end_tick = tick; end
            if (err)  begin sb_pop({tag, " err"}, EV_ERR);   fin = 1; end_tick = tick; end
            prev_act = eng_active;
            if (!fin) @(negedge clk);
        end
        check({tag, " finished_in_budget"}, fin, 1);
        @(negedge clk);
        rd_ack = 1'b0; eng_odata_valid = 1'b0; out_ready = 1'b0;
        #1;
        check({tag, " busy_after"}, busy, 0);
        check({tag, " cmd_ready_after"}, cmd_ready, 1);
        check({tag, " pulse_after"}, {done, err}, 2'b00);
        check({tag, " loads"}, loads, j.exp_loads);
        check({tag, " handoffs"}, hands, j.exp_hand);
        check({tag, " rd_req_seen"}, rdreqs > 0, j.exp_loads > 0);
        if (j.exp_hand > 0)
            check({tag, " out_valid_hold"}, ov_first, j.stall + 1);
        if (j.exp_timeout)
            check({tag, " timeout_cycles"}, end_tick - wait_entry, WAIT_MAX);
        if (j.exp_loads == 0)
            check({tag, " immediate_end"}, end_tick, 0);
`ifdef UDS_SEQ_PERF_EN
        check({tag, " perf_tiles"}, perf_tiles, j.exp_hand);
        if (j.stall > 0)
            check({tag, " perf_stall_min"}, perf_stall_cyc >= 32'(j.stall), 1);
`endif
    endtask

    task automatic run_reset_mid_job();
        int bad;
        @(negedge clk);
        check("rst cmd_ready_idle", cmd_ready, 1);
        cmd_mode = 2'b01; cmd_scale = 2'd0; cmd_tiles = 16'd3; cmd_valid = 1'b1;
        rd_ack = 1'b1; out_ready = 1'b1; eng_odata_valid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !eng_active; i++) @(negedge clk);
        check("rst reach_compute", eng_active, 1);
        check("rst eng_mode_before", eng_mode, 2'b01);
        rst_n = 1'b0;
        #1;
        check("rst outputs", {cmd_ready, rd_req, eng_active, eng_idata_valid, eng_mode, eng_scale,
                              out_valid, busy, done, err}, 12'b1000_0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            eng_odata_valid = i[0];
            @(negedge clk);
            if (done || err || busy) bad++;
        end
        eng_odata_valid = 1'b0; rd_ack = 1'b0; out_ready = 1'b0;
        check("rst no_pulse_after", bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        jobs[0]  = mk(2'b00, 2'd0, 3, 0, 0, 1, 0);
        jobs[1]  = mk(2'b00, 2'd0, 2, 5, 0, 1, 0);
        jobs[2]  = mk(2'b10, 2'd0, 3, 0, 0, 1, 0);
        jobs[3]  = mk(2'b00, 2'd0, 2, 0, 0, 0, 0);
        jobs[4]  = mk(2'b00, 2'd0, 0, 0, 0, 1, 0);
        jobs[5]  = mk(2'b01, 2'd0, 2, 0, 2, 1, 1);
        jobs[6]  = mk(2'b00, 2'd1, 1, 0, 0, 1, 0);
        jobs[7]  = mk(2'b11, 2'd0, 2, 0, 0, 1, 0);
        jobs[8]  = mk(2'b00, 2'd0, 4, 2, 0, 1, 0);
        jobs[9]  = mk(2'b01, 2'd2, 1, 0, 0, 1, 0);
        jobs[10] = mk(2'b01, 2'd0, 1, 1, 1, 1, 1);

        #1;
        check("reset outputs", {cmd_ready, rd_req, eng_active, eng_idata_valid, eng_mode, eng_scale,
                                out_valid, busy, done, err}, 12'b1000_0000_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (jobs[i]) run_job(i, jobs[i]);
        run_reset_mid_job();
        run_job(11, jobs[0]);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uds_seq_ctrl.md
UDS_SEQ_CTRL -- requirements
Module: uds_seq_ctrl

Interface
REQ-001 Parameter TILE_CNT_W, default 16, width of tile counters.
REQ-002 Parameter WAIT_MAX, default 8, maximum cycles from engine load to engine output valid before timeout.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  job command handshake.
REQ-006 cmd_mode  input  2  function_mode: [1] 1 = upsample, 0 = downsample; [0] 0 = max, 1 = avg.
REQ-007 cmd_scale  input  2  scale_factor: 0 = 2x2, 1 = 3x3.
REQ-008 cmd_tiles  input  TILE_CNT_W  tiles in job.
REQ-009 rd_req / rd_ack  output / input  1 / 1  tile fetch handshake to input buffer.
REQ-010 eng_active, eng_idata_valid  output  1 each  engine sequencing controls.
REQ-011 eng_mode / eng_scale  output  2 / 2  registered copy of the command, held for the whole job.
REQ-012 eng_odata_valid  input  1  engine result strobe.
REQ-013 out_valid / out_ready  output / input  1 / 1  result handoff to writeback.
REQ-014 busy, done, err  output  1 each  status; done and err are 1-cycle pulses.

Function
REQ-015 States: IDLE, FETCH, LOAD, COMPUTE, WAIT_OUT, HANDOFF.
REQ-016 IDLE: cmd_ready=1; a cmd_valid&&cmd_ready cycle latches mode, scale and tiles.
REQ-017 Supported combinations: downsample with scale 0, max or avg; any other combination pulses err the next cycle, produces no tiles and returns to IDLE.
REQ-018 cmd_tiles=0: done pulses the next cycle; no rd_req is issued.
REQ-019 FETCH: rd_req=1 until rd_ack; rd_ack moves the FSM to LOAD; rd_ack while rd_req=0 is ignored.
REQ-020 LOAD: exactly 1 cycle with eng_idata_valid=1 and eng_active=0.
REQ-021 COMPUTE: exactly 1 cycle with eng_active=1 and eng_idata_valid=0.
REQ-022 WAIT_OUT: eng_active=0; the FSM waits for eng_odata_valid and moves to HANDOFF when it arrives.
REQ-023 Timeout: if eng_odata_valid does not arrive within WAIT_MAX cycles of entering WAIT_OUT, err pulses, the job aborts and the FSM returns to IDLE.
REQ-024 HANDOFF: out_valid=1, held stable until out_ready.
REQ-025 No new FETCH starts until the handoff completes, because the engine output register is overwritten by the next tile.
REQ-026 After a handoff, the tile count increments; if count==tiles, done pulses in the same cycle as the transfer and the FSM goes to IDLE; otherwise it goes to FETCH.
REQ-027 Minimum per-tile latency from rd_ack to out_valid is 3 cycles (LOAD, COMPUTE, engine register).
REQ-028 busy=1 in every state except IDLE.
REQ-029 cmd_ready=0 whenever busy=1.
REQ-030 eng_odata_valid outside WAIT_OUT is ignored.
REQ-031 rd_ack and out_ready asserted in the same cycle each act only in their own state.

Reset
REQ-032 On reset the FSM enters IDLE and the counters and latched command clear.
REQ-033 Reset values: cmd_ready=1 and every other output 0.
REQ-034 Reset mid-job abandons the job; no done or err pulse is produced.

Configuration
REQ-035 UDS_SEQ_PERF_EN defined: 32-bit saturating outputs perf_busy_cyc, perf_stall_cyc and perf_tiles are present.
REQ-036 perf_busy_cyc counts cycles with busy=1.
REQ-037 perf_stall_cyc counts cycles in FETCH or HANDOFF where the handshake is not completed.
REQ-038 perf_tiles counts completed handoffs.
REQ-039 The perf counters clear on reset and on command accept.
REQ-040 UDS_SEQ_PERF_EN undefined: the perf ports and counters do not exist; all other behaviour is identical.

Structure
REQ-041 Shared package uds_pkg holds: the mode and scale encodings, the FSM state enum and the supported-combination check function.
REQ-042 Optional sub-module uds_seq_perf holds the perf counters, instantiated only under UDS_SEQ_PERF_EN.

Verification
REQ-043 Scenario: mode=00, scale=0, tiles=3, rd_ack and out_ready always 1, engine strobing 1 cycle after COMPUTE -> 3 LOAD pulses, 3 handoffs, done after the 3rd, busy falls the next cycle.
REQ-044 Scenario: tiles=2 with out_ready held low for 5 cycles on tile 1 -> out_valid held stable 6 cycles and the second rd_req not raised until the transfer.
REQ-045 Scenario: mode=10 (upsample) -> err pulse, no rd_req, cmd_ready high 2 cycles later.
REQ-046 Scenario: eng_odata_valid never asserted, WAIT_MAX=8 -> err pulse 8 cycles after entering WAIT_OUT, then IDLE.
REQ-047 Scenario: tiles=0 -> done the next cycle, no engine activity; rst_n low during COMPUTE -> all outputs at reset values immediately, no done.
REQ-048 Scenario: with UDS_SEQ_PERF_EN, tiles=4 with 2 out_ready stall cycles -> perf_tiles=4 and perf_stall_cyc of at least 2.
